// File: rtl/raster_scanner_if.sv
// Handshake-free bundle between the raster scanner and the video path.
// The scanner is the master; display/ROM logic consumes it as slave.
interface raster_scanner_if #(
    parameter int CW     = 10,
    parameter int ADDR_W = 12
);
    logic              i_en;
    logic [CW-1:0]     i_img_x0;
    logic [CW-1:0]     i_img_y0;
    logic [CW-1:0]     o_x;
    logic [CW-1:0]     o_y;
    logic              o_active;
    logic              o_hsync;
    logic              o_vsync;
    logic              o_frame_start;
    logic              o_line_end;
    logic              o_in_img;
    logic [ADDR_W-1:0] o_img_addr;

    modport master (
        input  i_en, i_img_x0, i_img_y0,
        output o_x, o_y, o_active, o_hsync, o_vsync,
        output o_frame_start, o_line_end, o_in_img, o_img_addr
    );

    modport slave (
        output i_en, i_img_x0, i_img_y0,
        input  o_x, o_y, o_active, o_hsync, o_vsync,
        input  o_frame_start, o_line_end, o_in_img, o_img_addr
    );
endinterface

// File: rtl/raster_scanner.sv
// Free-running raster counters with sync flags and a movable image window.
// Flags are computed from the next count so they register with it.
module raster_scanner #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int CW       = 10,
    parameter int ADDR_W   = 12
) (
    input logic clk,
    input logic rst,
    raster_scanner_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [CW:0] H_ACT = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_ACT = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] HS_LO = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_HI = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] VS_LO = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_HI = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW:0] IW    = (CW+1)'(IMG_W);
    localparam logic [CW:0] IH    = (CW+1)'(IMG_H);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

    logic [CW-1:0]     r_x, r_y, r_x0, r_y0;
    logic [ADDR_W-1:0] r_rowbase, r_addr;
    logic              r_active, r_hsync, r_vsync;
    logic              r_fs, r_le, r_in_img;

    logic              w_hwrap, w_fwrap, w_img_row;
    logic [CW-1:0]     w_nx, w_ny, w_nx0, w_ny0;
    logic [CW:0]       w_ex, w_ey, w_ex0, w_ey0;
    logic              w_nact, w_nin, w_nhs, w_nvs;
    logic [ADDR_W-1:0] w_nrow, w_naddr;

    always_comb begin
        w_hwrap = (r_x == H_LAST);
        w_fwrap = w_hwrap && (r_y == V_LAST);
        w_nx    = w_hwrap ? '0 : r_x + C_ONE;
        w_ny    = r_y;
        if (w_hwrap)
            w_ny = w_fwrap ? '0 : r_y + C_ONE;
        w_nx0   = w_fwrap ? bus.i_img_x0 : r_x0;
        w_ny0   = w_fwrap ? bus.i_img_y0 : r_y0;

        // One extra bit so a window past the edge clips instead of wrapping
        w_ex    = {1'b0, w_nx};
        w_ey    = {1'b0, w_ny};
        w_ex0   = {1'b0, w_nx0};
        w_ey0   = {1'b0, w_ny0};

        w_nact  = (w_ex < H_ACT) && (w_ey < V_ACT);
        w_nin   = w_nact
               && (w_ex >= w_ex0) && (w_ex < w_ex0 + IW)
               && (w_ey >= w_ey0) && (w_ey < w_ey0 + IH);
        w_nhs   = (w_ex >= HS_LO) && (w_ex < HS_HI);
        w_nvs   = (w_ey >= VS_LO) && (w_ey < VS_HI);

        w_img_row = ({1'b0, r_y} >= {1'b0, r_y0})
                 && ({1'b0, r_y} < {1'b0, r_y0} + IH);
        w_nrow  = r_rowbase;
        if (w_fwrap)
            w_nrow = '0;
        else if (w_hwrap && w_img_row)
            w_nrow = r_rowbase + ROW_STEP;

        // Row start reloads from the row base, otherwise step by one
        w_naddr = '0;
        if (w_nin)
            w_naddr = r_in_img ? r_addr + A_ONE : w_nrow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_rowbase <= '0;
            r_addr    <= '0;
            r_active  <= 1'b1;
            r_hsync   <= ~HS_POL;
            r_vsync   <= ~VS_POL;
            r_fs      <= 1'b1;
            r_le      <= 1'b0;
            r_in_img  <= 1'b1;
        end else if (bus.i_en) begin
            r_x       <= w_nx;
            r_y       <= w_ny;
            r_x0      <= w_nx0;
            r_y0      <= w_ny0;
            r_rowbase <= w_nrow;
            r_addr    <= w_naddr;
            r_active  <= w_nact;
            r_hsync   <= w_nhs ? HS_POL : ~HS_POL;
            r_vsync   <= w_nvs ? VS_POL : ~VS_POL;
            r_fs      <= (w_nx == '0) && (w_ny == '0);
            r_le      <= (w_nx == H_LAST);
            r_in_img  <= w_nin;
        end
    end

    assign bus.o_x           = r_x;
    assign bus.o_y           = r_y;
    assign bus.o_active      = r_active;
    assign bus.o_hsync       = r_hsync;
    assign bus.o_vsync       = r_vsync;
    assign bus.o_frame_start = r_fs;
    assign bus.o_line_end    = r_le;
    assign bus.o_in_img      = r_in_img;
    assign bus.o_img_addr    = r_addr;
endmodule

// File: doc/raster_scanner.md
# raster_scanner

Parametrised raster coordinate and sync generator for the VGA display path of the POS machine. It free-runs horizontal and vertical counters over a full frame, including blanking, and produces active-video, hsync and vsync flags. It also produces the linear pixel address for a movable image window, so image ROMs such as the image loader can be addressed directly. It replaces hand-written fixed-size x/y sweeps with one block sized entirely by parameters.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- HS_POL / VS_POL, 0 / 0, asserted level of hsync / vsync
- IMG_W / IMG_H, 64 / 64, image window size in pixels
- CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- ADDR_W, 12, image address width; must hold IMG_W*IMG_H-1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  pixel tick; counters advance only on clk edges with en=1
- img_x0, img_y0  in  CW each  image window top-left position; latched at frame wrap
- x, y  out  CW each  current horizontal / vertical count
- active  out  1  x<H_ACTIVE and y<V_ACTIVE
- hsync, vsync  out  1  sync outputs at HS_POL / VS_POL when asserted
- frame_start  out  1  high while x==0 and y==0
- line_end  out  1  high while x==H_TOTAL-1
- in_img  out  1  current pixel is inside the image window and active
- img_addr  out  ADDR_W  (y-y0)*IMG_W+(x-x0) when in_img, else 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- On a clk edge with en=1:
  - x increments; x==H_TOTAL-1 wraps x to 0 and increments y.
  - y==V_TOTAL-1 together with the x wrap sends y to 0 (frame wrap).
- On a clk edge with en=0: every output and internal register holds.
- Frame wrap: on the en edge that moves the counters to (0,0), img_x0/img_y0 are latched into x0/y0. The latched values apply to the whole new frame, including pixel (0,0). Input changes mid-frame have no effect until the next wrap.
- hsync is asserted while H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on y with the V parameters. When deasserted, each sync sits at the inverse of its POL.
- in_img = active && x0≤x<x0+IMG_W && y0≤y<y0+IMG_H.
  - Bounds are computed in CW+1 bits, so a window running past the active area is clipped, never wrapped.
- img_addr is generated incrementally, with no multiplier:
  - It increments on each in_img pixel.
  - A row-base register advances by IMG_W at the end of each image row.
  - It reads 0 whenever in_img=0.
- All outputs are registered and mutually consistent: x, y and every flag/address always describe the same pixel.

## Timing
- Reset (async, immediate): x=0, y=0, x0=y0=0, active=1, frame_start=1, line_end=0, hsync=~HS_POL, vsync=~VS_POL, in_img=1, img_addr=0.
- Latency: outputs change on the same clk edge as the counters. Zero cycles from count to flags.
- The first en edge after reset release moves to (1,0).
- Frame period = H_TOTAL*V_TOTAL en-qualified cycles.
- rst asserted mid-line or mid-frame immediately forces the reset values. The partial frame is discarded. x0/y0 return to 0, not to the pending inputs.
- en low exactly on the wrap edge: the wrap and the offset latch are both deferred to the next en edge.

## Test plan
Bench parameters: H 3/1/1/1 (H_TOTAL=6), V 2/1/1/1 (V_TOTAL=5), IMG_W=2, IMG_H=1, pol 0, CW=4, ADDR_W=2.
- Reset, en=0: x=0, y=0, active=1, frame_start=1, hsync=vsync=1, in_img=1, img_addr=0. Values hold for 5 cycles.
- en=1 for 30 cycles: x runs 0..5 then repeats; y runs 0..4. line_end at x=5. hsync=0 only at x=4. vsync=0 only for y=3. active only for x<3, y<2. frame_start returns at cycle 30.
- en toggled 1,0,0,1 from (2,0): the counters read (3,0), hold (3,0) for two cycles, then read (4,0). No flag glitches.
- img_x0=1, img_y0=1 applied at (2,0): the current frame keeps the window at (0,0), so in_img appears only at (0,0) addr 0 and (1,0) addr 1. The next frame gives in_img at (1,1) addr 0 and (2,1) addr 1 only.
- img_x0=2, img_y0=0: in_img at (2,0) with addr 0. At (3,0) in_img=0 and img_addr=0 (clipped, not wrapped).
- rst pulsed at (4,1): outputs immediately return to the reset values. x0/y0=0. The next en edge gives (1,0).
